sfence_seq: RTL and testbench

Sequencer for `sfence.vma` and its Svinval variants, all of which the privileged decoder reports as a single sfence request. It sits beside the privileged decoder in the M stage and stalls the pipeline while it works. It waits for the LSU and hardware page-table walker to go idle, then invalidates the shared I/D TLBs: a one-cycle flash flush for global fences, or a per-entry sweep for address- or ASID-qualified fences. It then releases the instruction to retire.

---
 rtl/sfence_seq_pkg.sv | 19 +
 rtl/sfence_sweepcnt.sv | 27 ++
 rtl/sfence_seq.sv | 151 +++++++++++++++
 tb/tb_sfence_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sfence_seq_pkg.sv
// Shared types and width helpers for the sfence.vma sequencer.
package sfence_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRAIN = 3'd1,
      FLASH = 3'd2,
      SWEEP = 3'd3,
      DONE  = 3'd4
   } sfstate_t;

   localparam int TLB_ENTRIES_DEF = 32;

   // Sweep index width for a TLB of the given (power-of-two) entry count.
   function automatic int idx_width(input int entries);
      return (entries < 2) ? 1 : $clog2(entries);
   endfunction

endpackage

// File: rtl/sfence_sweepcnt.sv
// Per-entry sweep index: clears to 0, counts up mod 2^IW, flags the last entry.
module sfence_sweepcnt #(
   parameter int IW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   output logic [IW-1:0] idx,
   output logic          last
);

   // Index register; clear has priority over increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (en) begin
         idx <= idx + 1'b1;
      end
   end

   // Entry count is a power of two, so the final entry is all-ones.
   assign last = &idx;

endmodule

// File: rtl/sfence_seq.sv
// sfence.vma sequencer: drains LSU/PTW, then flash-flushes or sweeps the TLBs.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for an armed, unflushed sfence request
//   DRAIN | fence accepted, waiting for LSU idle and page walker quiet
//   FLASH | one-cycle invalidate of every TLB entry (global fence)
//   SWEEP | one compare/invalidate per cycle over all entries
//   DONE  | one-cycle retire pulse, then back to IDLE
module sfence_seq
   import sfence_seq_pkg::*;
#(
   parameter  int XLEN        = 64,
   parameter  int ASID_BITS   = 16,
   parameter  int TLB_ENTRIES = TLB_ENTRIES_DEF,
   localparam int IW          = idx_width(TLB_ENTRIES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sfencevmaM,
   input  logic                 FlushM,
   input  logic                 Rs1ZeroM,
   input  logic                 Rs2ZeroM,
   input  logic [XLEN-1:0]      VAddrM,
   input  logic [ASID_BITS-1:0] ASIDM,
   input  logic                 LSUIdleM,
   input  logic                 PTWBusyM,
   output logic                 SfenceStallM,
   output logic                 TLBFlashM,
   output logic                 TLBInvValidM,
   output logic [IW-1:0]        TLBInvIdxM,
   output logic [XLEN-1:0]      TLBInvVAM,
   output logic [ASID_BITS-1:0] TLBInvASIDM,
   output logic                 TLBMatchVAM,
   output logic                 TLBMatchASIDM,
   output logic                 SfenceDoneM
);

   sfstate_t state;
   logic     armed;
   logic     global_q;
   logic     stall_q;
   logic     accept;
   logic     drained;
   logic     cnt_clr;
   logic     cnt_en;
   logic     cnt_last;

   // Gating with reset keeps the combinational stall low while reset is held.
   assign accept  = reset & (state == IDLE) & sfencevmaM & ~FlushM & armed;
   assign drained = LSUIdleM & ~PTWBusyM;
   assign cnt_clr = (state == DRAIN);
   assign cnt_en  = (state == SWEEP);

   sfence_sweepcnt #(
      .IW (IW)
   ) u_sweepcnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .idx   (TLBInvIdxM),
      .last  (cnt_last)
   );

   // A request held high across DONE must not refire; rearm after a low cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         armed <= 1'b1;
      end else if (accept) begin
         armed <= 1'b0;
      end else if (!sfencevmaM) begin
         armed <= 1'b1;
      end
   end

   // Operand capture on acceptance; held until the next accepted fence.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         TLBInvVAM     <= '0;
         TLBInvASIDM   <= '0;
         TLBMatchVAM   <= 1'b0;
         TLBMatchASIDM <= 1'b0;
         global_q      <= 1'b0;
      end else if (accept) begin
         TLBInvVAM     <= VAddrM;
         TLBInvASIDM   <= ASIDM;
         TLBMatchVAM   <= ~Rs1ZeroM;
         TLBMatchASIDM <= ~Rs2ZeroM;
         global_q      <= Rs1ZeroM & Rs2ZeroM;
      end
   end

   // Sequencer FSM with registered strobes computed from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         stall_q      <= 1'b0;
         TLBFlashM    <= 1'b0;
         TLBInvValidM <= 1'b0;
         SfenceDoneM  <= 1'b0;
      end else begin
         stall_q      <= 1'b0;
         TLBFlashM    <= 1'b0;
         TLBInvValidM <= 1'b0;
         SfenceDoneM  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= DRAIN;
                  stall_q <= 1'b1;
               end
            end
            DRAIN: begin
               stall_q <= 1'b1;
               if (drained) begin
                  if (global_q) begin
                     state     <= FLASH;
                     TLBFlashM <= 1'b1;
                  end else begin
                     state        <= SWEEP;
                     TLBInvValidM <= 1'b1;
                  end
               end
            end
            FLASH: begin
               state       <= DONE;
               SfenceDoneM <= 1'b1;
            end
            SWEEP: begin
               if (cnt_last) begin
                  state       <= DONE;
                  SfenceDoneM <= 1'b1;
               end else begin
                  stall_q      <= 1'b1;
                  TLBInvValidM <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign SfenceStallM = stall_q | accept;

endmodule

// File: tb/tb_sfence_seq.sv
// Directed bench for sfence_seq: per-cycle vector table plus multi-cycle sequences.
module tb_sfence_seq;

   localparam int XLEN = 64;
   localparam int ASID_BITS = 16;
   localparam int TLB_ENTRIES = 32;
   localparam int IW = 5;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 sfencevmaM;
   logic                 FlushM;
   logic                 Rs1ZeroM;
   logic                 Rs2ZeroM;
   logic [XLEN-1:0]      VAddrM;
   logic [ASID_BITS-1:0] ASIDM;
   logic                 LSUIdleM;
   logic                 PTWBusyM;
   logic                 SfenceStallM;
   logic                 TLBFlashM;
   logic                 TLBInvValidM;
   logic [IW-1:0]        TLBInvIdxM;
   logic [XLEN-1:0]      TLBInvVAM;
   logic [ASID_BITS-1:0] TLBInvASIDM;
   logic                 TLBMatchVAM;
   logic                 TLBMatchASIDM;
   logic                 SfenceDoneM;

   int n_chk = 0;
   int n_fail = 0;

   sfence_seq #(
      .XLEN        (XLEN),
      .ASID_BITS   (ASID_BITS),
      .TLB_ENTRIES (TLB_ENTRIES)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sfencevmaM    (sfencevmaM),
      .FlushM        (FlushM),
      .Rs1ZeroM      (Rs1ZeroM),
      .Rs2ZeroM      (Rs2ZeroM),
      .VAddrM        (VAddrM),
      .ASIDM         (ASIDM),
      .LSUIdleM      (LSUIdleM),
      .PTWBusyM      (PTWBusyM),
      .SfenceStallM  (SfenceStallM),
      .TLBFlashM     (TLBFlashM),
      .TLBInvValidM  (TLBInvValidM),
      .TLBInvIdxM    (TLBInvIdxM),
      .TLBInvVAM     (TLBInvVAM),
      .TLBInvASIDM   (TLBInvASIDM),
      .TLBMatchVAM   (TLBMatchVAM),
      .TLBMatchASIDM (TLBMatchASIDM),
      .SfenceDoneM   (SfenceDoneM)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic sf;
      logic fl;
      logic r1z;
      logic r2z;
      logic lsu_idle;
      logic ptw_busy;
      logic e_stall;
      logic e_flash;
      logic e_inv;
      logic e_done;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic sf, input logic fl, input logic r1z, input logic r2z,
                      input logic li, input logic pb, input logic es, input logic ef,
                      input logic ei, input logic ed);
      vec_t v;
      v = '{sf, fl, r1z, r2z, li, pb, es, ef, ei, ed};
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      sfencevmaM = 1'b0;
      FlushM     = 1'b0;
      Rs1ZeroM   = 1'b1;
      Rs2ZeroM   = 1'b1;
      VAddrM     = '0;
      ASIDM      = '0;
      LSUIdleM   = 1'b1;
      PTWBusyM   = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", SfenceStallM, 0);
      chk("rst_flash", TLBFlashM, 0);
      chk("rst_inv", TLBInvValidM, 0);
      chk("rst_idx", TLBInvIdxM, 0);
      chk("rst_va", TLBInvVAM, 0);
      chk("rst_done", SfenceDoneM, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      //   sf fl r1 r2 li pb | stall flash inv done
      // global fence, LSU idle: flash at +2, done at +3
      add(1, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0,  1, 1, 0, 0);
      add(0, 0, 1, 1, 1, 0,  0, 0, 0, 1);
      add(0, 0, 1, 1, 1, 0,  0, 0, 0, 0);
      // flush in the request cycle blocks acceptance
      add(1, 1, 1, 1, 1, 0,  0, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0,  0, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0,  0, 0, 0, 0);
      // drain wait: LSU busy 5 cycles, then PTW busy 2 cycles
      add(1, 0, 1, 1, 0, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 0, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 1, 1,  1, 0, 0, 0);
      add(0, 0, 1, 1, 1, 1,  1, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0,  1, 1, 0, 0);
      add(0, 0, 1, 1, 1, 0,  0, 0, 0, 1);
      add(0, 0, 1, 1, 1, 0,  0, 0, 0, 0);
      // request held high through DONE: one pulse, rearm after a low cycle
      add(1, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      add(1, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      add(1, 0, 1, 1, 1, 0,  1, 1, 0, 0);
      add(1, 0, 1, 1, 1, 0,  0, 0, 0, 1);
      add(1, 0, 1, 1, 1, 0,  0, 0, 0, 0);
      add(1, 0, 1, 1, 1, 0,  0, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0,  0, 0, 0, 0);
      add(1, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0,  1, 0, 0, 0);
      add(0, 0, 1, 1, 1, 0,  1, 1, 0, 0);
      add(0, 0, 1, 1, 1, 0,  0, 0, 0, 1);
      add(0, 0, 1, 1, 1, 0,  0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         sfencevmaM = vecs[i].sf;
         FlushM     = vecs[i].fl;
         Rs1ZeroM   = vecs[i].r1z;
         Rs2ZeroM   = vecs[i].r2z;
         LSUIdleM   = vecs[i].lsu_idle;
         PTWBusyM   = vecs[i].ptw_busy;
         #1;
         chk($sformatf("vec%0d_stall", i), SfenceStallM, vecs[i].e_stall);
         chk($sformatf("vec%0d_flash", i), TLBFlashM, vecs[i].e_flash);
         chk($sformatf("vec%0d_inv", i), TLBInvValidM, vecs[i].e_inv);
         chk($sformatf("vec%0d_done", i), SfenceDoneM, vecs[i].e_done);
         @(negedge clk);
      end
      idle_inputs();
      @(negedge clk);

      // selective fence by VA, flush asserted mid-sweep, operands changed after accept
      sfencevmaM = 1'b1;
      Rs1ZeroM   = 1'b0;
      Rs2ZeroM   = 1'b1;
      VAddrM     = 64'h0000_0000_8000_1000;
      ASIDM      = 16'h1234;
      #1;
      chk("sel_acc_stall", SfenceStallM, 1);
      @(negedge clk);
      sfencevmaM = 1'b0;
      Rs1ZeroM   = 1'b1;
      VAddrM     = 64'hDEAD_BEEF_CAFE_F00D;
      ASIDM      = 16'hFFFF;
      #1;
      chk("sel_drain_stall", SfenceStallM, 1);
      chk("sel_drain_inv", TLBInvValidM, 0);
      @(negedge clk);
      for (int k = 0; k < TLB_ENTRIES; k++) begin
         FlushM = (k == 8);
         #1;
         chk($sformatf("sel%0d_inv", k), TLBInvValidM, 1);
         chk($sformatf("sel%0d_idx", k), TLBInvIdxM, k);
         chk($sformatf("sel%0d_stall", k), SfenceStallM, 1);
         chk($sformatf("sel%0d_done", k), SfenceDoneM, 0);
         chk($sformatf("sel%0d_flash", k), TLBFlashM, 0);
         chk($sformatf("sel%0d_va", k), TLBInvVAM, 64'h0000_0000_8000_1000);
         chk($sformatf("sel%0d_asid", k), TLBInvASIDM, 16'h1234);
         chk($sformatf("sel%0d_mva", k), TLBMatchVAM, 1);
         chk($sformatf("sel%0d_masid", k), TLBMatchASIDM, 0);
         @(negedge clk);
      end
      FlushM = 1'b0;
      #1;
      chk("sel_done", SfenceDoneM, 1);
      chk("sel_done_inv", TLBInvValidM, 0);
      chk("sel_done_stall", SfenceStallM, 0);
      @(negedge clk);
      #1;
      chk("sel_after_done", SfenceDoneM, 0);
      chk("sel_after_stall", SfenceStallM, 0);
      @(negedge clk);

      // async reset at sweep index 10, then a fresh sweep from 0
      sfencevmaM = 1'b1;
      Rs1ZeroM   = 1'b1;
      Rs2ZeroM   = 1'b0;
      VAddrM     = 64'h0000_0000_0000_4000;
      ASIDM      = 16'h0042;
      @(negedge clk);
      sfencevmaM = 1'b0;
      @(negedge clk);
      repeat (10) @(negedge clk);
      #1;
      chk("pre_rst_idx", TLBInvIdxM, 10);
      chk("pre_rst_inv", TLBInvValidM, 1);
      chk("pre_rst_masid", TLBMatchASIDM, 1);
      reset = 1'b0;
      #1;
      chk("arst_stall", SfenceStallM, 0);
      chk("arst_inv", TLBInvValidM, 0);
      chk("arst_idx", TLBInvIdxM, 0);
      chk("arst_va", TLBInvVAM, 0);
      chk("arst_asid", TLBInvASIDM, 0);
      chk("arst_masid", TLBMatchASIDM, 0);
      chk("arst_done", SfenceDoneM, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      sfencevmaM = 1'b1;
      #1;
      chk("post_rst_acc", SfenceStallM, 1);
      @(negedge clk);
      sfencevmaM = 1'b0;
      @(negedge clk);
      #1;
      chk("post_rst_idx0", TLBInvIdxM, 0);
      chk("post_rst_inv", TLBInvValidM, 1);
      chk("post_rst_va", TLBInvVAM, 64'h0000_0000_0000_4000);
      repeat (TLB_ENTRIES) @(negedge clk);
      #1;
      chk("post_rst_done", SfenceDoneM, 1);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
